// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// =====================================================================
// Module   : cpu_pkg
// Purpose  : shared encodings and default widths for the RAM arbiter
// Revision : 1.0
// =====================================================================
package cpu_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// =====================================================================
// Module   : ram_arbiter_if
// Purpose  : CPU, DMA and RAM-side signals of the RAM arbiter
// Revision : 1.0
// =====================================================================
interface ram_arbiter_if #(
   parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
   parameter int DATA_W = cpu_pkg::DATA_W_DEF
);

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   logic              busy;
   logic              owner;

   // Arbiter view
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  ram_rdata,
      output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      output ram_addr, ram_wdata, ram_we, busy, owner
   );

   // Requester / RAM view
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output ram_rdata,
      input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      input  ram_addr, ram_wdata, ram_we, busy, owner
   );

endinterface
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
`default_nettype none
// =====================================================================
// Module   : rr_pick2
// Purpose  : combinational 2-way round-robin picker
// Revision : 1.0
// =====================================================================
module rr_pick2
   import cpu_pkg::*;
(
   input  wire logic [1:0] req_i,
   input  wire logic       last_i,
   output logic            valid_o,
   output logic            id_o
);

   // A tie goes to whichever requester was not granted last
   always_comb begin
      valid_o = |req_i;
      id_o    = REQ_CPU;
      if (req_i == 2'b11) begin
         id_o = ~last_i;
      end else if (req_i[1]) begin
         id_o = REQ_DMA;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : ram_arbiter
// Purpose  : shares a single-port RAM between CPU and DMA, one access at a time
// Revision : 1.0
// =====================================================================
module ram_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input wire logic     clk,
   input wire logic     rst,
   ram_arbiter_if.slave bus
);

   localparam int              LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

   logic                pick_valid;
   logic                pick_id;

   rr_pick2 u_pick (
      .req_i   ({bus.dma_req, bus.cpu_req}),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .id_o    (pick_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= REQ_CPU;
         last_q      <= REQ_DMA;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_cnt_q   <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_cnt_q   <= lat_cnt_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_cnt_d   = lat_cnt_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               owner_d   = pick_id;
               last_d    = pick_id;
               lat_cnt_d = LAT_LOAD;
               state_d   = ST_ACCESS;
               if (pick_id == REQ_DMA) begin
                  we_d    = bus.dma_we;
                  addr_d  = bus.dma_addr;
                  wdata_d = bus.dma_wdata;
               end else begin
                  we_d    = bus.cpu_we;
                  addr_d  = bus.cpu_addr;
                  wdata_d = bus.cpu_wdata;
               end
            end
         end

         // Writes take one cycle; reads wait out the RAM latency and
         // capture on the last ACCESS edge.
         ST_ACCESS: begin
            if (we_q) begin
               state_d = ST_DONE;
            end else if (lat_cnt_q == '0) begin
               state_d = ST_DONE;
               if (owner_q == REQ_DMA) begin
                  dma_rdata_d = bus.ram_rdata;
               end else begin
                  cpu_rdata_d = bus.ram_rdata;
               end
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = wdata_q;
   assign bus.ram_we    = (state_q == ST_ACCESS) && we_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.owner     = owner_q;
   assign bus.cpu_ack   = (state_q == ST_DONE) && (owner_q == REQ_CPU);
   assign bus.dma_ack   = (state_q == ST_DONE) && (owner_q == REQ_DMA);
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;

   a_ack_exclusive : assert property (@(posedge clk) disable iff (rst)
      !(bus.cpu_ack && bus.dma_ack));

   a_we_single : assert property (@(posedge clk) disable iff (rst)
      bus.ram_we |=> !bus.ram_we);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : tb_ram_arbiter
// Purpose  : scoreboard bench for ram_arbiter with RD_LAT=1 and RD_LAT=3 builds
// Revision : 1.0
// =====================================================================
module tb_ram_arbiter;
   import cpu_pkg::*;

   localparam int AW = 9;
   localparam int DW = 32;

   typedef struct packed {
      logic          who;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct packed {
      logic          cpu_ack;
      logic          dma_ack;
      logic          ram_we;
      logic          busy;
      logic          owner;
      logic [AW-1:0] ram_addr;
      logic [DW-1:0] ram_wdata;
      logic [DW-1:0] cpu_rdata;
      logic [DW-1:0] dma_rdata;
   } snap_t;

   typedef struct {
      int            lat;
      int            we_cyc;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      int            busy_cyc;
      bit            other_ack;
      bit            ok;
   } res_t;

   logic clk = 1'b0;
   logic rst1;
   logic rst3;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (b1)
   );

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
      .clk (clk),
      .rst (rst3),
      .bus (b3)
   );

   // RAM models: latency 1 reads the current address, latency 3 reads it two edges late
   logic [DW-1:0] mem1 [512];
   logic [DW-1:0] mem3 [512];
   logic [AW-1:0] p3a = '0;
   logic [AW-1:0] p3b = '0;

   always @(posedge clk) begin
      if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_wdata;
      if (b3.ram_we) mem3[b3.ram_addr] <= b3.ram_wdata;
      p3a <= b3.ram_addr;
      p3b <= p3a;
   end

   assign b1.ram_rdata = mem1[b1.ram_addr];
   assign b3.ram_rdata = mem3[p3b];

   function automatic snap_t snap(input bit d3);
      if (d3) return {b3.cpu_ack, b3.dma_ack, b3.ram_we, b3.busy, b3.owner,
                      b3.ram_addr, b3.ram_wdata, b3.cpu_rdata, b3.dma_rdata};
      return {b1.cpu_ack, b1.dma_ack, b1.ram_we, b1.busy, b1.owner,
              b1.ram_addr, b1.ram_wdata, b1.cpu_rdata, b1.dma_rdata};
   endfunction

   task automatic drive(input bit d3, input logic who, input logic req, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (d3 && who == REQ_DMA) begin
         b3.dma_req = req; b3.dma_we = we; b3.dma_addr = a; b3.dma_wdata = d;
      end else if (d3) begin
         b3.cpu_req = req; b3.cpu_we = we; b3.cpu_addr = a; b3.cpu_wdata = d;
      end else if (who == REQ_DMA) begin
         b1.dma_req = req; b1.dma_we = we; b1.dma_addr = a; b1.dma_wdata = d;
      end else begin
         b1.cpu_req = req; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = d;
      end
   endtask

   // Issues one request from a negedge and returns at the negedge its ack is seen
   task automatic txn(input bit d3, input logic who, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, output res_t r);
      snap_t s;
      int    n = 0;
      int    first_busy = -1;
      r = '{lat: -1, we_cyc: 0, wa: '0, wd: '0, busy_cyc: 0, other_ack: 1'b0, ok: 1'b0};
      drive(d3, who, 1'b1, we, a, d);
      while (n < 40 && !r.ok) begin
         @(negedge clk);
         n++;
         s = snap(d3);
         if (s.busy) begin
            r.busy_cyc++;
            if (first_busy < 0) first_busy = n;
         end
         if (s.ram_we) begin
            r.we_cyc++;
            r.wa = s.ram_addr;
            r.wd = s.ram_wdata;
         end
         if (who == REQ_DMA ? s.cpu_ack : s.dma_ack) r.other_ack = 1'b1;
         if (who == REQ_DMA ? s.dma_ack : s.cpu_ack) begin
            r.ok  = 1'b1;
            r.lat = (first_busy < 0) ? -1 : n - first_busy + 1;
         end
      end
   endtask

   task automatic test_reset();
      snap_t s;
      rst1 = 1'b1;
      rst3 = 1'b1;
      drive(0, REQ_CPU, 0, 0, '0, '0);
      drive(0, REQ_DMA, 0, 0, '0, '0);
      drive(1, REQ_CPU, 0, 0, '0, '0);
      drive(1, REQ_DMA, 0, 0, '0, '0);
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (b1.ram_we !== 1'b0 || b3.ram_we !== 1'b0)
            begin errors++; $display("FAIL reset_we: got %b/%b, want 0/0", b1.ram_we, b3.ram_we); end
      end
      s = snap(0);
      checks++;
      if (s !== '0) begin errors++; $display("FAIL reset_out_lat1: got %h, want 0", s); end
      s = snap(1);
      checks++;
      if (s !== '0) begin errors++; $display("FAIL reset_out_lat3: got %h, want 0", s); end
      rst1 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);
      s = snap(0);
      checks++;
      if (s !== '0) begin errors++; $display("FAIL post_reset_idle: got %h, want 0", s); end
   endtask

   task automatic test_fairness();
      exp_t e;
      int   acks = 0;
      int   n = 0;
      int   ci = 0;
      int   di = 0;
      logic [DW-1:0] got;
      sb.push_back('{who: REQ_CPU, rd: 1'b0, addr: 9'h010, data: 32'hA1A10010});
      sb.push_back('{who: REQ_DMA, rd: 1'b0, addr: 9'h020, data: 32'hB2B20020});
      sb.push_back('{who: REQ_CPU, rd: 1'b1, addr: 9'h020, data: 32'hB2B20020});
      sb.push_back('{who: REQ_DMA, rd: 1'b1, addr: 9'h010, data: 32'hA1A10010});
      drive(0, REQ_CPU, 1, 1, 9'h010, 32'hA1A10010);
      drive(0, REQ_DMA, 1, 1, 9'h020, 32'hB2B20020);
      while (acks < 4 && n < 100) begin
         @(negedge clk);
         n++;
         if (b1.cpu_ack || b1.dma_ack) begin
            e = sb.pop_front();
            acks++;
            checks++;
            if (b1.cpu_ack && b1.dma_ack)
               begin errors++; $display("FAIL ack_overlap: got both acks, want one"); end
            checks++;
            if (b1.dma_ack !== e.who || b1.owner !== e.who)
               begin errors++; $display("FAIL owner_seq[%0d]: got ack=%b owner=%b, want %b", acks, b1.dma_ack, b1.owner, e.who); end
            if (e.rd) begin
               got = e.who ? b1.dma_rdata : b1.cpu_rdata;
               checks++;
               if (got !== e.data)
                  begin errors++; $display("FAIL fair_rdata[%0d]: got %h, want %h", acks, got, e.data); end
            end
            if (b1.cpu_ack) begin
               if (ci == 0) drive(0, REQ_CPU, 1, 0, 9'h020, '0);
               else         drive(0, REQ_CPU, 0, 0, '0, '0);
               ci++;
            end
            if (b1.dma_ack) begin
               if (di == 0) drive(0, REQ_DMA, 1, 0, 9'h010, '0);
               else         drive(0, REQ_DMA, 0, 0, '0, '0);
               di++;
            end
         end
      end
      checks++;
      if (acks != 4) begin errors++; $display("FAIL fair_timeout: got %0d acks, want 4", acks); end
      drive(0, REQ_CPU, 0, 0, '0, '0);
      drive(0, REQ_DMA, 0, 0, '0, '0);
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_cpu_write_read();
      res_t          r;
      snap_t         s;
      exp_t          e;
      logic [DW-1:0] dma_before;
      dma_before = b1.dma_rdata;
      sb.push_back('{who: REQ_CPU, rd: 1'b0, addr: 9'h005, data: 32'hDEADBEEF});
      txn(0, REQ_CPU, 1'b1, 9'h005, 32'hDEADBEEF, r);
      e = sb.pop_front();
      s = snap(0);
      checks++;
      if (!r.ok) begin errors++; $display("FAIL wr_timeout: got no cpu_ack, want ack"); end
      checks++;
      if (r.we_cyc != 1) begin errors++; $display("FAIL wr_we_cycles: got %0d, want 1", r.we_cyc); end
      checks++;
      if (r.wa !== e.addr || r.wd !== e.data)
         begin errors++; $display("FAIL wr_bus: got %h/%h, want %h/%h", r.wa, r.wd, e.addr, e.data); end
      checks++;
      if (r.lat != 2) begin errors++; $display("FAIL wr_latency: got %0d, want 2", r.lat); end
      checks++;
      if (s.owner !== e.who) begin errors++; $display("FAIL wr_owner: got %b, want %b", s.owner, e.who); end
      drive(0, REQ_CPU, 0, 0, '0, '0);
      @(negedge clk);

      sb.push_back('{who: REQ_CPU, rd: 1'b1, addr: 9'h005, data: 32'hDEADBEEF});
      txn(0, REQ_CPU, 1'b0, 9'h005, '0, r);
      e = sb.pop_front();
      s = snap(0);
      checks++;
      if (r.lat != 2) begin errors++; $display("FAIL rd_latency: got %0d, want 2", r.lat); end
      checks++;
      if (s.cpu_rdata !== e.data) begin errors++; $display("FAIL rd_data: got %h, want %h", s.cpu_rdata, e.data); end
      checks++;
      if (r.we_cyc != 0) begin errors++; $display("FAIL rd_we: got %0d we cycles, want 0", r.we_cyc); end
      checks++;
      if (s.dma_rdata !== dma_before || r.other_ack)
         begin errors++; $display("FAIL rd_dma_side: got %h ack=%b, want %h ack=0", s.dma_rdata, r.other_ack, dma_before); end
      drive(0, REQ_CPU, 0, 0, '0, '0);
      @(negedge clk);
      checks++;
      if (b1.cpu_rdata !== e.data) begin errors++; $display("FAIL rd_hold: got %h, want %h", b1.cpu_rdata, e.data); end
   endtask

   task automatic test_dma_writes();
      exp_t e;
      int   n = 0;
      int   acks = 0;
      int   last_we = -1;
      bit   cpu_seen = 1'b0;
      for (int i = 0; i < 4; i++)
         sb.push_back('{who: REQ_DMA, rd: 1'b0, addr: AW'(i), data: 32'hC0DE0000 + i});
      drive(0, REQ_DMA, 1, 1, sb[0].addr, sb[0].data);
      while (acks < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (b1.cpu_ack) cpu_seen = 1'b1;
         if (b1.ram_we) begin
            if (last_we >= 0) begin
               checks++;
               if (n - last_we != 3) begin errors++; $display("FAIL dma_interval: got %0d, want 3", n - last_we); end
            end
            last_we = n;
         end
         if (b1.dma_ack) begin
            e = sb.pop_front();
            acks++;
            checks++;
            if (mem1[e.addr] !== e.data)
               begin errors++; $display("FAIL dma_mem[%0d]: got %h, want %h", e.addr, mem1[e.addr], e.data); end
            if (sb.size() > 0) drive(0, REQ_DMA, 1, 1, sb[0].addr, sb[0].data);
            else               drive(0, REQ_DMA, 0, 0, '0, '0);
         end
      end
      checks++;
      if (acks != 4) begin errors++; $display("FAIL dma_timeout: got %0d acks, want 4", acks); end
      checks++;
      if (cpu_seen) begin errors++; $display("FAIL dma_cpu_ack: got cpu_ack pulse, want none"); end
      drive(0, REQ_DMA, 0, 0, '0, '0);
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_rdlat3();
      res_t  r;
      snap_t s;
      exp_t  e;
      txn(1, REQ_CPU, 1'b1, 9'h040, 32'h12345678, r);
      checks++;
      if (!r.ok || r.lat != 2) begin errors++; $display("FAIL l3_wr_latency: got ok=%b lat=%0d, want 1/2", r.ok, r.lat); end
      drive(1, REQ_CPU, 0, 0, '0, '0);
      @(negedge clk);
      txn(1, REQ_CPU, 1'b1, 9'h041, 32'hAAAA5555, r);
      drive(1, REQ_CPU, 0, 0, '0, '0);
      @(negedge clk);

      sb.push_back('{who: REQ_CPU, rd: 1'b1, addr: 9'h040, data: 32'h12345678});
      txn(1, REQ_CPU, 1'b0, 9'h040, '0, r);
      e = sb.pop_front();
      s = snap(1);
      checks++;
      if (r.lat != 4) begin errors++; $display("FAIL l3_rd_latency: got %0d, want 4", r.lat); end
      checks++;
      if (r.busy_cyc != 4) begin errors++; $display("FAIL l3_busy: got %0d cycles, want 4", r.busy_cyc); end
      checks++;
      if (s.cpu_rdata !== e.data) begin errors++; $display("FAIL l3_rdata: got %h, want %h", s.cpu_rdata, e.data); end
      drive(1, REQ_CPU, 0, 0, '0, '0);
      @(negedge clk);
      checks++;
      if (b3.busy !== 1'b0) begin errors++; $display("FAIL l3_busy_end: got %b, want 0", b3.busy); end
   endtask

   task automatic test_reset_abort();
      res_t  r;
      snap_t s;
      exp_t  e;
      int    n = 0;
      sb.push_back('{who: REQ_CPU, rd: 1'b1, addr: 9'h041, data: 32'hAAAA5555});
      drive(1, REQ_CPU, 1, 0, 9'h041, '0);
      while (!b3.busy && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (b3.busy !== 1'b1) begin errors++; $display("FAIL abort_start: got busy=%b, want 1", b3.busy); end
      @(negedge clk);
      rst3 = 1'b1;
      #1;
      checks++;
      if ({b3.ram_we, b3.busy, b3.cpu_ack, b3.dma_ack} !== 4'b0)
         begin errors++; $display("FAIL abort_outputs: got %b, want 0000", {b3.ram_we, b3.busy, b3.cpu_ack, b3.dma_ack}); end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (b3.cpu_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got %b, want 0", b3.cpu_ack); end
      end
      rst3 = 1'b0;
      txn(1, REQ_CPU, 1'b0, 9'h041, '0, r);
      e = sb.pop_front();
      s = snap(1);
      checks++;
      if (!r.ok || r.lat != 4) begin errors++; $display("FAIL abort_regrant: got ok=%b lat=%0d, want 1/4", r.ok, r.lat); end
      checks++;
      if (s.cpu_rdata !== e.data) begin errors++; $display("FAIL abort_rdata: got %h, want %h", s.cpu_rdata, e.data); end
      drive(1, REQ_CPU, 0, 0, '0, '0);
      @(negedge clk);

      drive(1, REQ_DMA, 1, 1, 9'h050, 32'h5A5A5A5A);
      n = 0;
      while (!b3.ram_we && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (b3.ram_we !== 1'b1) begin errors++; $display("FAIL abort_wr_start: got ram_we=%b, want 1", b3.ram_we); end
      rst3 = 1'b1;
      #1;
      checks++;
      if (b3.ram_we !== 1'b0) begin errors++; $display("FAIL abort_wr_we: got %b, want 0", b3.ram_we); end
      drive(1, REQ_DMA, 0, 0, '0, '0);
      @(negedge clk);
      rst3 = 1'b0;
      @(negedge clk);
      checks++;
      if (b3.dma_ack !== 1'b0 || b3.busy !== 1'b0)
         begin errors++; $display("FAIL abort_wr_idle: got ack=%b busy=%b, want 0/0", b3.dma_ack, b3.busy); end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_cpu_write_read();
      test_dma_writes();
      test_rdlat3();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, want finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port RAM between the CPU memory path and a DMA requester (input-port loader / debug).
- The CPU side is the MAR/MDR traffic from the control unit's fetch, ld and st sequences.
- Arbitration is 2-way round-robin, and one transaction is outstanding at a time.
- A per-requester ack pulse replaces the control unit's fixed-timing assumption about RAM.

Parameters:
- ADDR_W, 9, RAM word-address width (512 words)
- DATA_W, 32, data width
- RD_LAT, 1, RAM read latency in cycles (at least 1); ram_rdata is valid RD_LAT cycles after the address is driven

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  reset; asynchronous, active-high
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid when cpu_ack=1 on a read, held afterwards
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA equivalents
- dma_ack  out  1  DMA completion pulse
- dma_rdata  out  DATA_W  DMA read data
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high in ACCESS and DONE
- owner  out  1  0 = CPU, 1 = DMA; requester of the current or last transaction

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = DMA, so CPU wins the first tie.
- Reset is asynchronous. Asserting it mid-transaction forces ram_we=0 immediately.
  - The in-flight transaction is dropped with no ack.
  - A requester still holding req after release is re-arbitrated as a new request.
- State machine states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On the grant edge: latch we, addr and wdata into holding registers; set owner and last_grant; load lat_cnt; go to ACCESS.
- ACCESS:
  - ram_addr and ram_wdata are driven from the holding registers.
  - Write: ram_we=1 for exactly one cycle, then go to DONE.
  - Read: ram_we=0; lat_cnt counts RD_LAT cycles.
  - On the final ACCESS edge, ram_rdata is captured into the owner's rdata register; go to DONE.
- DONE:
  - The owner's ack is 1 for one cycle; requests are ignored; go to IDLE.
  - The other requester's rdata is untouched.
  - A write leaves rdata unchanged.
- Latency, counted from the grant edge to the cycle ack is high:
  - write: 2 cycles
  - read: RD_LAT+1 cycles
  - throughput: one transaction per 3 cycles (write) or RD_LAT+2 cycles (read).
- Handshake rules:
  - The requester holds req, we, addr and wdata stable until it samples ack.
  - It deasserts req on the edge ending DONE, or keeps req high to issue the next transaction.
  - The arbiter samples signals only in IDLE; changes during ACCESS/DONE have no effect on the current transaction.
- Fairness: with both requesters continuously requesting, grants strictly alternate, so each waits at most one transaction.
- ram_addr and ram_wdata hold their last values outside ACCESS; ram_we is 0 outside ACCESS.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2
  - requester IDs REQ_CPU=1'b0, REQ_DMA=1'b1
  - default ADDR_W and DATA_W
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: valid, id.
- The FSM, latency counter and holding registers stay in ram_arbiter.

Test Plan:
- Reset held for 3 cycles then released → all outputs 0; no ram_we; first tie goes to CPU.
- CPU write addr 9'h005 data 32'hDEADBEEF (RD_LAT=1) → ram_we=1 for one cycle with ram_addr=5; cpu_ack 2 cycles after grant. Then CPU read of 5 → cpu_ack 2 cycles after grant with cpu_rdata=32'hDEADBEEF; dma_rdata unchanged.
- Both req asserted together and held for 4 transactions → owner sequence CPU, DMA, CPU, DMA; acks never overlap; each requester sees a gap of at least one transaction between its own grants.
- DMA-only continuous writes to addresses 0..3 → one write every 3 cycles; RAM contents 0..3 correct; cpu_ack never pulses.
- Reset asserted during a read ACCESS with RD_LAT=3 → ram_we=0 and no ack for the aborted read. After release the held req is re-granted and acked 4 cycles after its grant.
- RD_LAT=3 build, CPU read of a preloaded 32'h12345678 → ack exactly 4 cycles after grant; cpu_rdata=32'h12345678; busy high for 4 cycles.
